branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- Consumes the Zero/Sign flags from the ID-stage branch compare block. Decides whether the branch in ID is taken, and owns the IF-stage program counter.
- No delay slot. A taken branch or jump redirects the PC and kills the wrong-path instruction entering IF/ID.
- When IF is held at the moment a branch resolves, the redirect is buffered and applied once IF is released.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_hold  input  1  IF not ready (instruction memory wait); PC must not advance.
- id_stall  input  1  ID hazard stall; the branch in ID is not resolved this cycle.
- id_valid  input  1  ID holds a real instruction (not a bubble).
- br_type  input  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 unconditional jump (j/jal/jr).
- zero  input  1  Zero flag from the compare block (rs-rt or rs-0).
- sign  input  1  Sign flag from the compare block.
- br_target  input  32  branch/jump target computed in ID.
- pc  output  32  current fetch PC (registered).
- flush_id  output  1  load a bubble into IF/ID at the next edge (combinational).
- redirect_pending  output  1  a taken redirect is buffered (registered).
- br_count  output  32  resolved branch count (see Optional Feature).
- taken_count  output  32  taken branch count (see Optional Feature).

Behaviour:
- Taken condition, by br_type:
  - 1: zero
  - 2: !zero
  - 3: sign|zero
  - 4: !sign&!zero
  - 5: sign
  - 6: !sign
  - 7: 1
  - 0: 0
- resolve = id_valid & !id_stall & !redirect_pending.
- take = resolve & taken.
- Targets are always word-aligned: br_target[1:0] is forced to 2'b00 when used or buffered.
- Reset (async, takes effect immediately):
  - pc = RESET_PC, redirect_pending = 0, pending target = 0.
  - br_count = 0, taken_count = 0.
  - flush_id = 0 while rst is high.
- Registered state has two states, RUN and PEND (redirect_pending = 0/1).
- RUN, per clock edge:
  - take & !pc_hold: pc <= aligned br_target; stay RUN.
  - take & pc_hold: pend_target <= aligned br_target; go PEND; pc unchanged.
  - !take & !pc_hold: pc <= pc + PC_STEP, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - !take & pc_hold: pc unchanged.
- PEND, per clock edge:
  - !pc_hold: pc <= pend_target; go RUN.
  - pc_hold: remain in PEND, pc unchanged.
  - No new branch is resolved in PEND; ID contents are wrong-path and are flushed.
- flush_id = take | redirect_pending.
  - It stays high for every PEND cycle, including the release cycle.
- Latency: PC redirect occurs at the first edge after take with pc_hold low; one bubble minimum per taken branch.
- id_stall=1 with a valid branch: no resolution; pc still follows the pc_hold rules (sequential advance is permitted, the upstream hazard unit holds IF/ID).
- id_valid=0: br_type, zero and sign are ignored.
- Reset mid-PEND: the buffered redirect is discarded and pc returns to RESET_PC.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - br_count increments on each resolve edge with br_type 1-6.
  - taken_count increments on each take edge with br_type 1-6.
  - Jumps (br_type 7) are not counted.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: both ports are tied to 0 and no counter registers are built.

Test Plan:
- Reset: rst=1 for 2 cycles, then low, no branches -> pc=0x3000, then 0x3004, 0x3008 on successive edges; flush_id=0.
- beq taken: at pc=0x3008, id_valid=1, br_type=1, zero=1, br_target=0x3040 -> flush_id=1 that cycle; next pc=0x3040. With zero=0 instead -> flush_id=0, next pc=0x300C.
- Sign-based types: bltz with sign=1 taken; bgez with sign=1 not taken; blez with zero=1, sign=0 taken; bgtz with zero=1 not taken -> flush_id and pc match each case. br_target=0x3043 -> pc=0x3040.
- Held redirect: take with pc_hold=1 for 3 cycles, br_target=0x3100 -> redirect_pending=1 and flush_id=1 for all 3 cycles, pc frozen; pc=0x3100 at the edge pc_hold falls; pending cleared.
- Stall and ordering:
  - id_stall=1 with a taken bne -> no flush and no redirect.
  - Async rst during PEND -> pc=0x3000 and pending=0 immediately.
  - pc=0xFFFF_FFFC with no branch -> next pc=0x0000_0000.
- BRANCH_STATS_EN: 5 conditional branches (3 taken) plus 2 jumps -> br_count=5, taken_count=3. Undefined build -> both counters read 0.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Purpose: resolves the ID-stage branch from Zero/Sign flags and owns the IF-stage PC.
// Latency: redirect lands on the first edge after take with pc_hold low; flush_id is combinational.
// Backpressure: pc_hold freezes the PC; a redirect taken under hold is buffered until release.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   pc_hold           - IF not ready, PC must not advance
//   id_stall          - ID hazard stall, branch in ID not resolved this cycle
//   id_valid          - ID holds a real instruction
//   br_type[2:0]      - 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 jump
//   zero, sign        - compare flags
//   br_target[31:0]   - branch/jump target (low two bits forced to zero)
//   pc[31:0]          - registered fetch PC
//   flush_id          - bubble IF/ID at the next edge
//   redirect_pending  - a taken redirect is buffered
//   br_count, taken_count - conditional branch statistics
//
// Optional build macro: BRANCH_STATS_EN enables the statistics counters;
// without it both count ports read zero and no counter flops exist.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_hold,
    input  logic        id_stall,
    input  logic        id_valid,
    input  logic [2:0]  br_type,
    input  logic        zero,
    input  logic        sign,
    input  logic [31:0] br_target,
    output logic [31:0] pc,
    output logic        flush_id,
    output logic        redirect_pending,
    output logic [31:0] br_count,
    output logic [31:0] taken_count
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        taken;
    logic        resolve;
    logic        take;
    logic [31:0] target_aligned;

    always_comb begin
        taken = 1'b0;
        case (br_type)
            3'd1:    taken = zero;
            3'd2:    taken = !zero;
            3'd3:    taken = sign | zero;
            3'd4:    taken = !sign & !zero;
            3'd5:    taken = sign;
            3'd6:    taken = !sign;
            3'd7:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // While a redirect is buffered the instruction in ID is wrong-path,
    // so nothing new may resolve.
    assign resolve        = id_valid & !id_stall & (state_q == RUN);
    assign take           = resolve & taken;
    assign target_aligned = {br_target[31:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        case (state_q)
            RUN: begin
                if (take) begin
                    if (pc_hold) begin
                        pend_target_d = target_aligned;
                        state_d       = PEND;
                    end else begin
                        pc_d = target_aligned;
                    end
                end else if (!pc_hold) begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            PEND: begin
                if (!pc_hold) begin
                    pc_d    = pend_target_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc               = pc_q;
    assign redirect_pending = (state_q == PEND);
    // Held high through every PEND cycle, including the one where hold drops.
    assign flush_id         = !rst & (take | redirect_pending);

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] taken_count_q, taken_count_d;
    logic        is_cond;

    // Jumps (type 7) and non-branches (type 0) are excluded from statistics.
    assign is_cond = (br_type != 3'd0) && (br_type != 3'd7);

    always_comb begin
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;
        if (resolve && is_cond && (br_count_q != 32'hFFFF_FFFF))
            br_count_d = br_count_q + 32'd1;
        if (take && is_cond && (taken_count_q != 32'hFFFF_FFFF))
            taken_count_d = taken_count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_q    <= 32'h0;
            taken_count_q <= 32'h0;
        end else begin
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign br_count    = br_count_q;
    assign taken_count = taken_count_q;
`else
    assign br_count    = 32'h0;
    assign taken_count = 32'h0;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;

    logic        clk;
    logic        rst;
    logic        pc_hold;
    logic        id_stall;
    logic        id_valid;
    logic [2:0]  br_type;
    logic        zero;
    logic        sign;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic        flush_id;
    logic        redirect_pending;
    logic [31:0] br_count;
    logic [31:0] taken_count;

    int n_cmp = 0;
    int n_bad = 0;

    branch_pc_unit dut (
        .clk              (clk),
        .rst              (rst),
        .pc_hold          (pc_hold),
        .id_stall         (id_stall),
        .id_valid         (id_valid),
        .br_type          (br_type),
        .zero             (zero),
        .sign             (sign),
        .br_target        (br_target),
        .pc               (pc),
        .flush_id         (flush_id),
        .redirect_pending (redirect_pending),
        .br_count         (br_count),
        .taken_count      (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // advance one edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic v, input logic [2:0] t, input logic z,
                          input logic s, input logic [31:0] tgt);
        id_valid  = v;
        br_type   = t;
        zero      = z;
        sign      = s;
        br_target = tgt;
        #1;
    endtask

    logic [31:0] exp_br, exp_tk;

    initial begin
`ifdef BRANCH_STATS_EN
        exp_br = 32'd6;
        exp_tk = 32'd3;
`else
        exp_br = 32'd0;
        exp_tk = 32'd0;
`endif
        rst = 1'b1; pc_hold = 1'b0; id_stall = 1'b0;
        id_valid = 1'b0; br_type = 3'd0; zero = 1'b0; sign = 1'b0; br_target = 32'h0;

        // reset
        tick(); tick();
        chk("rst_pc", pc, 32'h3000);
        chk("rst_flush", {31'b0, flush_id}, 32'd0);
        chk("rst_pend", {31'b0, redirect_pending}, 32'd0);
        chk("rst_brc", br_count, 32'd0);
        rst = 1'b0;
        tick(); chk("seq1_pc", pc, 32'h3004);
        tick(); chk("seq2_pc", pc, 32'h3008);
        chk("seq_flush", {31'b0, flush_id}, 32'd0);

        // beq taken
        set_br(1'b1, 3'd1, 1'b1, 1'b0, 32'h3040);
        chk("beq_t_flush", {31'b0, flush_id}, 32'd1);
        tick(); chk("beq_t_pc", pc, 32'h3040);
        // beq not taken
        set_br(1'b1, 3'd1, 1'b0, 1'b0, 32'h3080);
        chk("beq_nt_flush", {31'b0, flush_id}, 32'd0);
        tick(); chk("beq_nt_pc", pc, 32'h3044);
        // bltz sign=1 taken, unaligned target
        set_br(1'b1, 3'd5, 1'b0, 1'b1, 32'h3043);
        chk("bltz_flush", {31'b0, flush_id}, 32'd1);
        tick(); chk("bltz_pc", pc, 32'h3040);
        // bgez sign=1 not taken
        set_br(1'b1, 3'd6, 1'b0, 1'b1, 32'h3200);
        chk("bgez_flush", {31'b0, flush_id}, 32'd0);
        tick(); chk("bgez_pc", pc, 32'h3044);
        // blez zero=1 sign=0 taken
        set_br(1'b1, 3'd3, 1'b1, 1'b0, 32'h3080);
        chk("blez_flush", {31'b0, flush_id}, 32'd1);
        tick(); chk("blez_pc", pc, 32'h3080);
        // bgtz zero=1 not taken
        set_br(1'b1, 3'd4, 1'b1, 1'b0, 32'h3300);
        chk("bgtz_flush", {31'b0, flush_id}, 32'd0);
        tick(); chk("bgtz_pc", pc, 32'h3084);

        // stalled taken bne: no resolution, PC still advances
        id_stall = 1'b1;
        set_br(1'b1, 3'd2, 1'b0, 1'b0, 32'h3400);
        chk("stall_flush", {31'b0, flush_id}, 32'd0);
        tick(); chk("stall_pc", pc, 32'h3088);
        id_stall = 1'b0;

        // bubble with jump type: ignored
        set_br(1'b0, 3'd7, 1'b0, 1'b0, 32'h3500);
        chk("bubble_flush", {31'b0, flush_id}, 32'd0);
        tick(); chk("bubble_pc", pc, 32'h308C);

        // held redirect: jump while IF held for 3 cycles
        pc_hold = 1'b1;
        set_br(1'b1, 3'd7, 1'b0, 1'b0, 32'h3100);
        chk("hold0_flush", {31'b0, flush_id}, 32'd1);
        chk("hold0_pend", {31'b0, redirect_pending}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("hold_pend", {31'b0, redirect_pending}, 32'd1);
            chk("hold_flush", {31'b0, flush_id}, 32'd1);
            chk("hold_pc", pc, 32'h308C);
        end
        pc_hold = 1'b0;
        #1;
        chk("rel_flush", {31'b0, flush_id}, 32'd1);
        tick();
        chk("rel_pc", pc, 32'h3100);
        chk("rel_pend", {31'b0, redirect_pending}, 32'd0);
        set_br(1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        chk("rel_flush_off", {31'b0, flush_id}, 32'd0);

        // wrap at top of address space
        set_br(1'b1, 3'd7, 1'b0, 1'b0, 32'hFFFF_FFFF);
        tick(); chk("top_pc", pc, 32'hFFFF_FFFC);
        set_br(1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        tick(); chk("wrap_pc", pc, 32'h0000_0000);

        // statistics: 6 resolved conditionals, 3 taken, jumps excluded
        chk("br_count", br_count, exp_br);
        chk("taken_count", taken_count, exp_tk);

        // async reset while a redirect is buffered
        pc_hold = 1'b1;
        set_br(1'b1, 3'd7, 1'b0, 1'b0, 32'h3200);
        tick();
        chk("pend_before_rst", {31'b0, redirect_pending}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h3000);
        chk("arst_pend", {31'b0, redirect_pending}, 32'd0);
        chk("arst_flush", {31'b0, flush_id}, 32'd0);
        chk("arst_brc", br_count, 32'd0);
        chk("arst_tkc", taken_count, 32'd0);
        set_br(1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        pc_hold = 1'b0;
        tick();
        rst = 1'b0;
        tick(); chk("post_rst_pc", pc, 32'h3004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
